// File: rtl/alu_operand_sequencer_if.sv
// Bus between the operator/ALU side and alu_operand_sequencer.
//   master : drives data_in, enter, undo (operator) and result_in, flags_in (ALU)
//   slave  : the sequencer; drives A, B, OpCode, result_q, flags_q, stage, done, op_count
interface alu_operand_sequencer_if #(
  parameter int unsigned M = 16
);
  logic [M-1:0] data_in;
  logic         enter;
  logic         undo;
  logic [M-1:0] result_in;
  logic [4:0]   flags_in;
  logic [M-1:0] A;
  logic [M-1:0] B;
  logic [1:0]   OpCode;
  logic [M-1:0] result_q;
  logic [4:0]   flags_q;
  logic [2:0]   stage;
  logic         done;
  logic [7:0]   op_count;

  modport master (
    output data_in, enter, undo, result_in, flags_in,
    input  A, B, OpCode, result_q, flags_q, stage, done, op_count
  );

  modport slave (
    input  data_in, enter, undo, result_in, flags_in,
    output A, B, OpCode, result_q, flags_q, stage, done, op_count
  );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Operator-driven front end for a combinational ALU: collects A, B and OpCode
// from a shared data bus on enter edges, waits one cycle for the ALU to settle,
// then captures Result/Flags and pulses done.
// Ports:
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of alu_operand_sequencer_if (buttons, data, ALU I/O,
//             registered operands, captured result, stage, done, op_count)
module alu_operand_sequencer #(
  parameter int unsigned M = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  alu_operand_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_WAIT_A  = 3'd0,
    S_WAIT_B  = 3'd1,
    S_WAIT_OP = 3'd2,
    S_CALC    = 3'd3,
    S_SHOW    = 3'd4
  } state_e;

  state_e       state_q, state_d;
  logic [M-1:0] a_q, a_d;
  logic [M-1:0] b_q, b_d;
  logic [1:0]   opcode_q, opcode_d;
  logic [M-1:0] result_q, result_d;
  logic [4:0]   flags_q, flags_d;
  logic [7:0]   op_count_q, op_count_d;
  logic         done_q, done_d;
  logic         enter_q, enter_d;
  logic         undo_q, undo_d;

  logic         enter_ev;
  logic         undo_ev;

  // Rising-edge detect; undo takes priority when both arrive together
  always_comb begin
    enter_d  = bus.enter;
    undo_d   = bus.undo;
    undo_ev  = bus.undo & ~undo_q;
    enter_ev = bus.enter & ~enter_q & ~undo_ev;
  end

  // Next-state and register-load logic
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    opcode_d   = opcode_q;
    result_d   = result_q;
    flags_d    = flags_q;
    op_count_d = op_count_q;
    done_d     = 1'b0;

    case (state_q)
      S_WAIT_A: begin
        if (enter_ev) begin
          a_d     = bus.data_in;
          state_d = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        if (undo_ev) begin
          state_d = S_WAIT_A;
        end else if (enter_ev) begin
          b_d     = bus.data_in;
          state_d = S_WAIT_OP;
        end
      end
      S_WAIT_OP: begin
        if (undo_ev) begin
          state_d = S_WAIT_B;
        end else if (enter_ev) begin
          opcode_d = bus.data_in[1:0];
          state_d  = S_CALC;
        end
      end
      // One settling cycle for the ALU, then capture
      S_CALC: begin
        result_d   = bus.result_in;
        flags_d    = bus.flags_in;
        op_count_d = op_count_q + 8'd1;
        done_d     = 1'b1;
        state_d    = S_SHOW;
      end
      S_SHOW: begin
        if (undo_ev) begin
          state_d = S_WAIT_OP;
        end else if (enter_ev) begin
          state_d = S_WAIT_A;
        end
      end
      default: state_d = S_WAIT_A;
    endcase
  end

  // State register; button history resets high so a held button is not an event
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_WAIT_A;
      a_q        <= '0;
      b_q        <= '0;
      opcode_q   <= '0;
      result_q   <= '0;
      flags_q    <= '0;
      op_count_q <= '0;
      done_q     <= 1'b0;
      enter_q    <= 1'b1;
      undo_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      opcode_q   <= opcode_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
      op_count_q <= op_count_d;
      done_q     <= done_d;
      enter_q    <= enter_d;
      undo_q     <= undo_d;
    end
  end

  assign bus.A        = a_q;
  assign bus.B        = b_q;
  assign bus.OpCode   = opcode_q;
  assign bus.result_q = result_q;
  assign bus.flags_q  = flags_q;
  assign bus.stage    = state_q;
  assign bus.done     = done_q;
  assign bus.op_count = op_count_q;

endmodule
